cofi_ctrl: RTL and testbench

Controller for the composite-like horizontal blend filter in the video output path. It generates the filter's pixel clock enable and measures the active line width of the incoming video. It decides when blending is on: forced on, forced off, or automatic for hi-res content. Enable changes are applied only at frame boundaries, so the filter never switches mid-line.

---
 rtl/cofi_ctrl.sv | 120 ++++++++++++
 tb/tb_cofi_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cofi_ctrl.sv
// cofi_ctrl: pixel-enable divider, active line width measurement and
// frame-synchronous enable control for the horizontal blend filter.
module cofi_ctrl #(
  parameter int unsigned DIV_W  = 3,
  parameter int unsigned MEAS_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  ce_div,
  input  logic [MEAS_W-1:0] auto_thresh,
  input  logic              hblank,
  input  logic              vblank,
  output logic              pix_ce,
  output logic              cofi_enable,
  output logic [MEAS_W-1:0] active_width
);

  typedef enum logic [1:0] {
    S_OFF     = 2'd0,
    S_ARM_ON  = 2'd1,
    S_ON      = 2'd2,
    S_ARM_OFF = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [MEAS_W-1:0] wcnt;
  logic [MEAS_W-1:0] frame_max;
  logic [MEAS_W-1:0] fm;
  logic              hblank_d;
  logic              vblank_d;
  logic              line_end;
  logic              commit;
  logic              want;

  // Pixel-enable divider: one-clk pulse every ce_div+1 clks.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      pix_ce  <= 1'b0;
    end else if (div_cnt >= ce_div) begin
      div_cnt <= '0;
      pix_ce  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      pix_ce  <= 1'b0;
    end
  end

  // Edge detection on sampled blanking and the width committed for this frame.
  always_comb begin
    line_end = pix_ce & hblank & ~hblank_d;
    commit   = pix_ce & vblank & ~vblank_d;
    fm       = frame_max;
    if (line_end && (wcnt > frame_max)) begin
      fm = wcnt;
    end
    want = (fm >= auto_thresh);
  end

  // Active-width measurement, advanced on pixel-enable samples only.
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt         <= '0;
      frame_max    <= '0;
      hblank_d     <= 1'b1;
      vblank_d     <= 1'b1;
      active_width <= '0;
    end else if (pix_ce) begin
      hblank_d <= hblank;
      vblank_d <= vblank;
      if (hblank) begin
        wcnt <= '0;
      end else if (wcnt != '1) begin
        wcnt <= wcnt + MEAS_W'(1);
      end
      // A line ending on the commit sample is already folded into fm.
      if (commit) begin
        active_width <= fm;
        frame_max    <= '0;
      end else if (line_end && (wcnt > frame_max)) begin
        frame_max <= wcnt;
      end
    end
  end

  // Enable FSM next state; steps only on a frame commit.
  always_comb begin
    state_nxt = state;
    if (commit) begin
      case (mode)
        2'd1: state_nxt = S_ON;
        2'd2: begin
          case (state)
            S_OFF:     state_nxt = want ? S_ARM_ON : S_OFF;
            S_ARM_ON:  state_nxt = want ? S_ON     : S_OFF;
            S_ON:      state_nxt = want ? S_ON     : S_ARM_OFF;
            S_ARM_OFF: state_nxt = want ? S_ON     : S_OFF;
            default:   state_nxt = S_OFF;
          endcase
        end
        default: state_nxt = S_OFF;
      endcase
    end
  end

  // State register; enable is registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_OFF;
      cofi_enable <= 1'b0;
    end else begin
      state       <= state_nxt;
      cofi_enable <= (state_nxt == S_ON) || (state_nxt == S_ARM_OFF);
    end
  end

endmodule

// File: tb/tb_cofi_ctrl.sv
// Self-checking bench for cofi_ctrl with a frame-level behavioural model.
module tb_cofi_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [2:0]  ce_div;
  logic [11:0] auto_thresh;
  logic        hblank;
  logic        vblank;
  logic        pix_ce;
  logic        cofi_enable;
  logic [11:0] active_width;

  int checks = 0;
  int errs   = 0;
  int prints = 0;
  bit chk_on = 1'b0;
  bit vb     = 1'b0;

  cofi_ctrl #(.DIV_W(3), .MEAS_W(12)) dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .ce_div       (ce_div),
    .auto_thresh  (auto_thresh),
    .hblank       (hblank),
    .vblank       (vblank),
    .pix_ce       (pix_ce),
    .cofi_enable  (cofi_enable),
    .active_width (active_width)
  );

  always #5 clk = ~clk;

  // Reference model: clks since last pulse, completed line widths per frame,
  // and enable as "current value plus one pending disagreement".
  bit m_pix   = 1'b0;
  int m_since = 0;
  bit m_en    = 1'b0;
  bit m_pend  = 1'b0;
  int m_aw    = 0;
  int m_run   = 0;
  bit m_hp    = 1'b1;
  bit m_vp    = 1'b1;
  int lines[$];
  int m_fm;
  bit m_want;

  always @(posedge clk) begin
    if (reset) begin
      m_pix = 0; m_since = 0; m_en = 0; m_pend = 0; m_aw = 0; m_run = 0;
      m_hp = 1; m_vp = 1; lines.delete();
    end else begin
      if (m_pix) begin
        if (hblank && !m_hp) lines.push_back(m_run);
        if (vblank && !m_vp) begin
          m_fm = 0;
          foreach (lines[i]) if (lines[i] > m_fm) m_fm = lines[i];
          lines.delete();
          m_aw = m_fm;
          m_want = (m_fm >= int'(auto_thresh));
          if (mode == 2'd1) begin
            m_en = 1; m_pend = 0;
          end else if (mode == 2'd2) begin
            if (m_want != m_en) begin
              if (m_pend) begin m_en = m_want; m_pend = 0; end
              else m_pend = 1;
            end else begin
              m_pend = 0;
            end
          end else begin
            m_en = 0; m_pend = 0;
          end
        end
        m_run = hblank ? 0 : ((m_run < 4095) ? m_run + 1 : 4095);
        m_hp = hblank;
        m_vp = vblank;
      end
      if (m_since >= int'(ce_div)) begin m_since = 0; m_pix = 1; end
      else begin m_since = m_since + 1; m_pix = 0; end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (pix_ce !== m_pix || cofi_enable !== m_en || active_width !== m_aw[11:0]) begin
        errs++;
        if (prints < 20) begin
          prints++;
          $display("FAIL cycle_cmp t=%0t pix_ce=%b/%b cofi_enable=%b/%b active_width=%0d/%0d (got/exp)",
                   $time, pix_ce, m_pix, cofi_enable, m_en, active_width, m_aw);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one (hblank, vblank) pair and let exactly one pix_ce sample take it.
  task automatic sample(input bit h, input bit v);
    hblank = h;
    vblank = v;
    while (!m_pix) tick();
    tick();
  endtask

  task automatic line(input int w, input int nb);
    for (int i = 0; i < w; i++) sample(1'b0, vb);
    for (int i = 0; i < nb; i++) sample(1'b1, vb);
  endtask

  // Lines with vblank low, then the commit sample, then a short vblank tail.
  task automatic frame(input int w, input int n);
    vb = 1'b0;
    for (int i = 0; i < n; i++) line(w, 4);
    vb = 1'b1;
    for (int i = 0; i < 3; i++) sample(1'b1, 1'b1);
  endtask

  initial begin
    reset = 1; mode = 0; ce_div = 3'd2; auto_thresh = 12'd400; hblank = 1; vblank = 1;
    tick(); tick(); tick();
    chk_on = 1;
    chk("reset_pix_ce", pix_ce, 0);
    chk("reset_enable", cofi_enable, 0);
    chk("reset_width", active_width, 0);
    reset = 0;

    // Divider pattern 0,0,1 then constant 1.
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("div_pattern", pix_ce, (k % 3 == 0) ? 1 : 0);
    end
    ce_div = 3'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("div_zero", pix_ce, 1);
    end

    // Measurement with mode 0.
    vb = 0;
    line(320, 8); line(352, 8); line(256, 8);
    sample(1'b1, 1'b1);
    chk("meas_width", active_width, 352);
    chk("meas_enable", cofi_enable, 0);
    vb = 1; sample(1'b1, 1'b1); sample(1'b1, 1'b1);

    // Auto mode hysteresis.
    mode = 2; auto_thresh = 12'd400;
    frame(512, 3); chk("auto_c1", cofi_enable, 0); chk("auto_w1", active_width, 512);
    frame(512, 3); chk("auto_c2", cofi_enable, 1);
    frame(320, 3); chk("auto_armoff", cofi_enable, 1); chk("auto_w3", active_width, 320);
    frame(512, 3); chk("auto_backon", cofi_enable, 1);
    frame(320, 3); chk("auto_off1", cofi_enable, 1);
    frame(320, 3); chk("auto_off2", cofi_enable, 0);

    // Forced on set mid-frame: no effect before the commit sample.
    mode = 0;
    vb = 0;
    line(200, 4);
    mode = 1;
    line(200, 4);
    chk("forced_early", cofi_enable, 0);
    sample(1'b1, 1'b1);
    chk("forced_on", cofi_enable, 1);
    vb = 1; sample(1'b1, 1'b1);
    mode = 3;
    frame(200, 2); chk("forced_mode3", cofi_enable, 0);

    // Last line end coinciding with vblank rise.
    vb = 0;
    line(300, 4);
    for (int i = 0; i < 640; i++) sample(1'b0, 1'b0);
    sample(1'b1, 1'b1);
    chk("coincide_width", active_width, 640);
    vb = 1; sample(1'b1, 1'b1);

    // Width counter saturation.
    vb = 0;
    line(5000, 4);
    sample(1'b1, 1'b1);
    chk("sat_width", active_width, 4095);
    vb = 1; sample(1'b1, 1'b1);

    // Reset mid-line while auto ON.
    mode = 2;
    frame(512, 2); frame(512, 2);
    chk("pre_reset_on", cofi_enable, 1);
    vb = 0;
    for (int i = 0; i < 100; i++) sample(1'b0, 1'b0);
    reset = 1; hblank = 0; vblank = 1;
    tick();
    chk("rst_pix_ce", pix_ce, 0);
    chk("rst_enable", cofi_enable, 0);
    chk("rst_width", active_width, 0);
    reset = 0;
    sample(1'b1, 1'b1);
    for (int i = 0; i < 50; i++) sample(1'b0, 1'b1);
    sample(1'b1, 1'b1);
    chk("rst_no_commit", active_width, 0);
    vb = 0;
    line(200, 4);
    sample(1'b1, 1'b1);
    chk("rst_fresh_commit", active_width, 200);
    chk("rst_fresh_enable", cofi_enable, 0);

    // Randomized frames with divider, mode and threshold changes.
    for (int f = 0; f < 30; f++) begin
      int nl;
      if ($urandom_range(0, 3) == 0) ce_div = 3'($urandom_range(0, 7));
      mode = 2'($urandom_range(0, 3));
      auto_thresh = 12'($urandom_range(20, 120));
      vb = 0;
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) begin
        int w;
        w = $urandom_range(0, 120);
        if (l == nl - 1 && $urandom_range(0, 2) == 0) begin
          for (int i = 0; i < w; i++) sample(1'b0, 1'b0);
        end else begin
          line(w, $urandom_range(1, 5));
        end
        if ($urandom_range(0, 15) == 0) ce_div = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) == 0) begin
        reset = 1; tick(); reset = 0;
      end
      vb = 1;
      for (int i = 0; i < $urandom_range(1, 4); i++) sample(1'($urandom_range(0, 1)), 1'b1);
    end

    tick(); tick();
    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
